// File: rtl/pc_sequencer_if.sv
// Handshake and status bundle between the seq processor control FSM and its
// surroundings (next-PC logic, instruction/data memories, register file).
interface pc_sequencer_if;
    logic [31:0] new_pc;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_ready;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_we;
    logic        pc_we;
    logic        retire;
    logic [31:0] retired_count;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;

    modport master (
        input  new_pc, imem_ready, imem_rdata, dmem_ready,
        output pc, ir, imem_req, dmem_req, dmem_we, reg_we, pc_we, retire,
               retired_count, state, halted, illegal
    );

    modport slave (
        output new_pc, imem_ready, imem_rdata, dmem_ready,
        input  pc, ir, imem_req, dmem_req, dmem_we, reg_we, pc_we, retire,
               retired_count, state, halted, illegal
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for the seq processor: owns PC and IR, walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB and counts retirements.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  OP_HALT  = 6'h3F
) (
    input  logic clk,
    input  logic rst,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, count_q;
    logic        halted_q, illegal_q;

    logic [5:0]  op;
    logic        imem_req, dmem_req, dmem_we, reg_we, advance;
    logic        load_ir, set_halt, set_illegal;

    assign op = ir_q[31:26];

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        advance     = 1'b0;
        load_ir     = 1'b0;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    load_ir = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_HALT) begin
                    set_halt = 1'b1;
                    state_d  = S_HALT;
                end else if (op == OP_J) begin
                    advance = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ) begin
                    state_d = S_EXEC;
                end else begin
                    set_halt    = 1'b1;
                    set_illegal = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_RTYPE:     state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        // new_pc already carries the taken/not-taken choice
                        advance = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        set_halt    = 1'b1;
                        set_illegal = 1'b1;
                        state_d     = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
                if (bus.dmem_ready) begin
                    if (op == OP_SW) begin
                        advance = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                advance = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            count_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_ir)     ir_q      <= bus.imem_rdata;
            if (advance)     pc_q      <= bus.new_pc;
            if (advance)     count_q   <= count_q + 32'd1;
            if (set_halt)    halted_q  <= 1'b1;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    // Strobes are masked while reset is held so a pending handshake drops at once
    assign bus.imem_req      = imem_req & ~rst;
    assign bus.dmem_req      = dmem_req & ~rst;
    assign bus.dmem_we       = dmem_we  & ~rst;
    assign bus.reg_we        = reg_we   & ~rst;
    assign bus.pc_we         = advance  & ~rst;
    assign bus.retire        = advance  & ~rst;
    assign bus.pc            = pc_q;
    assign bus.ir            = ir_q;
    assign bus.retired_count = count_q;
    assign bus.state         = state_q;
    assign bus.halted        = halted_q;
    assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written halt/reset
// sequences, and random instruction streams checked per instruction.
module tb_pc_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if bus_if ();

    pc_sequencer #(.RESET_PC(RESET_PC), .OP_HALT(6'h3F)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_cnt;

    typedef struct {
        logic [31:0] instr;
        int          dw;
        logic [31:0] npc;
        logic [31:0] st;    // expected state per cycle, one nibble each, left first
        logic [4:0]  strb;  // {reg_we,dmem_req,dmem_we,pc_we,retire} in the retire cycle
    } vec_t;

    vec_t tab[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int base_lat(input logic [5:0] op);
        case (op)
            6'h02:   return 2;
            6'h04:   return 3;
            6'h00:   return 4;
            6'h2B:   return 4;
            6'h23:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus_if.imem_ready = 1'b0;
        bus_if.dmem_ready = 1'b0;
        bus_if.imem_rdata = 32'h0;
        bus_if.new_pc     = 32'h0;
        cyc();
        @(negedge clk);
        chk("rst_strobes", {bus_if.imem_req, bus_if.dmem_req, bus_if.dmem_we,
                            bus_if.reg_we, bus_if.pc_we, bus_if.retire}, 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_pc", bus_if.pc, RESET_PC);
        chk("rst_ir", bus_if.ir, 32'h0);
        chk("rst_state", bus_if.state, 32'd0);
        chk("rst_count", bus_if.retired_count, 32'h0);
        chk("rst_halted", bus_if.halted, 32'h0);
        chk("rst_illegal", bus_if.illegal, 32'h0);
        exp_cnt = 32'h0;
    endtask

    // Runs one instruction from FETCH until its retire pulse; iw/dw are the
    // instruction/data memory wait cycles. Expectations come from the
    // instruction-level latency and strobe rules.
    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                             input logic [31:0] npc, input bit noise,
                             input bit tabchk, input logic [31:0] tst, input logic [4:0] tstrb);
        logic [5:0]  op;
        bit          mem, sw, wr;
        int          exp_len, c;
        int          n_imem, n_dmem, n_dwe, n_regwe, n_pcwe, n_split, n_unstable;
        logic [31:0] old_pc;
        bit          done;
        op = instr[31:26];
        mem = (op == 6'h23) || (op == 6'h2B);
        sw  = (op == 6'h2B);
        wr  = (op == 6'h00) || (op == 6'h23);
        exp_len = iw + base_lat(op) + (mem ? dw : 0);
        old_pc = bus_if.pc;
        n_imem = 0; n_dmem = 0; n_dwe = 0; n_regwe = 0; n_pcwe = 0; n_split = 0; n_unstable = 0;
        done = 1'b0;
        c = 0;
        bus_if.new_pc = npc;
        while (!done && c < 40) begin
            if (c < iw) begin
                bus_if.imem_ready = 1'b0;
            end else if (c == iw) begin
                bus_if.imem_ready = 1'b1;
                bus_if.imem_rdata = instr;
            end else begin
                bus_if.imem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus_if.imem_rdata = $urandom;
            end
            if (mem && c >= iw + 3) bus_if.dmem_ready = (c >= iw + 3 + dw);
            else                    bus_if.dmem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (tabchk && c < 8) chk("tab_state", {29'h0, bus_if.state}, {28'h0, tst[31-4*c -: 4]});
            n_imem  += int'(bus_if.imem_req);
            n_dmem  += int'(bus_if.dmem_req);
            n_dwe   += int'(bus_if.dmem_we);
            n_regwe += int'(bus_if.reg_we);
            n_pcwe  += int'(bus_if.pc_we);
            if (bus_if.pc_we != bus_if.retire) n_split++;
            if (bus_if.imem_req && bus_if.pc != old_pc) n_unstable++;
            if (bus_if.retire) begin
                done = 1'b1;
                if (tabchk)
                    chk("tab_retire_strobes", {27'h0, bus_if.reg_we, bus_if.dmem_req, bus_if.dmem_we,
                                               bus_if.pc_we, bus_if.retire}, {27'h0, tstrb});
            end
            cyc();
            c++;
        end
        exp_cnt = exp_cnt + 32'd1;
        chk("cycles", c, exp_len);
        chk("pc_after", bus_if.pc, npc);
        chk("state_after", bus_if.state, 32'd0);
        chk("count", bus_if.retired_count, exp_cnt);
        chk("ir", bus_if.ir, instr);
        chk("imem_req_cycles", n_imem, iw + 1);
        chk("pc_stable_fetch", n_unstable, 0);
        chk("dmem_req_cycles", n_dmem, mem ? dw + 1 : 0);
        chk("dmem_we_cycles", n_dwe, sw ? dw + 1 : 0);
        chk("reg_we_cycles", n_regwe, wr ? 1 : 0);
        chk("pc_we_cycles", n_pcwe, 1);
        chk("pc_we_retire_split", n_split, 0);
    endtask

    task automatic halt_seq(input logic [5:0] op, input logic exp_illegal);
        int n_strb;
        logic [31:0] pc0, ir0;
        do_reset();
        bus_if.imem_ready = 1'b1;
        bus_if.imem_rdata = {op, 26'h155_5555};
        cyc();
        bus_if.imem_ready = 1'b0;
        cyc();
        chk("halt_state", bus_if.state, 32'd5);
        chk("halt_halted", bus_if.halted, 32'd1);
        chk("halt_illegal", bus_if.illegal, {31'h0, exp_illegal});
        chk("halt_count", bus_if.retired_count, 32'h0);
        pc0 = bus_if.pc;
        ir0 = bus_if.ir;
        n_strb = 0;
        for (int i = 0; i < 10; i++) begin
            bus_if.imem_ready = 1'($urandom_range(0, 1));
            bus_if.dmem_ready = 1'($urandom_range(0, 1));
            bus_if.imem_rdata = $urandom;
            bus_if.new_pc     = $urandom;
            @(negedge clk);
            if (bus_if.imem_req || bus_if.dmem_req || bus_if.dmem_we ||
                bus_if.reg_we || bus_if.pc_we || bus_if.retire) n_strb++;
            cyc();
        end
        chk("halt_no_strobes", n_strb, 0);
        chk("halt_pc_frozen", bus_if.pc, pc0);
        chk("halt_ir_frozen", bus_if.ir, ir0);
        chk("halt_count_frozen", bus_if.retired_count, 32'h0);
        chk("halt_still", bus_if.state, 32'd5);
    endtask

    initial begin
        tab[0] = '{32'h0000_0020, 0, 32'h0000_0004, 32'h0124_0000, 5'b10011};
        tab[1] = '{32'h8C01_0004, 2, 32'h0000_0008, 32'h0123_3340, 5'b10011};
        tab[2] = '{32'hAC01_0004, 0, 32'h0000_000C, 32'h0123_0000, 5'b01111};
        tab[3] = '{32'h1000_0000, 0, 32'h0000_0040, 32'h0120_0000, 5'b00011};
        tab[4] = '{32'h0800_0000, 0, 32'h0000_0100, 32'h0100_0000, 5'b00011};

        do_reset();
        for (int i = 0; i < 5; i++)
            run_instr(tab[i].instr, 0, tab[i].dw, tab[i].npc, 1'b0, 1'b1, tab[i].st, tab[i].strb);

        halt_seq(6'h3F, 1'b0);
        halt_seq(6'h11, 1'b1);
        do_reset();

        // Reset during a pending data handshake
        bus_if.imem_ready = 1'b1;
        bus_if.imem_rdata = 32'h8C01_0004;
        bus_if.new_pc     = 32'h0000_0080;
        cyc();
        bus_if.imem_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("memwait_state", bus_if.state, 32'd3);
        chk("memwait_dmem_req", bus_if.dmem_req, 32'd1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("memwait_rst_dmem_req", bus_if.dmem_req, 32'd0);
        chk("memwait_rst_pc_we", bus_if.pc_we, 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("memrst_state", bus_if.state, 32'd0);
        chk("memrst_pc", bus_if.pc, RESET_PC);
        chk("memrst_dmem_req", bus_if.dmem_req, 32'd0);
        chk("memrst_count", bus_if.retired_count, 32'h0);
        cyc();
        exp_cnt = 32'h0;

        // Random instruction stream with random memory waits and ready noise
        for (int i = 0; i < 60; i++) begin
            logic [5:0]  rop;
            logic [31:0] rin, rpc;
            case ($urandom_range(0, 4))
                0:       rop = 6'h00;
                1:       rop = 6'h23;
                2:       rop = 6'h2B;
                3:       rop = 6'h04;
                default: rop = 6'h02;
            endcase
            rin = {rop, 26'($urandom)};
            rpc = $urandom & 32'hFFFF_FFFC;
            run_instr(rin, $urandom_range(0, 3), $urandom_range(0, 3), rpc, 1'b1, 1'b0, 32'h0, 5'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the seq processor; owns the PC register and the instruction register (IR).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the memory request handshakes.
- Decides the cycle in which the PC takes the next-PC value; that value comes from the existing combinational next-PC logic, which is fed by this block's pc and ir outputs plus the ALU zero flag.
- Also counts retired instructions and halts on halt or illegal opcodes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
OP_HALT, 6'h3F, opcode that stops the sequencer

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
new_pc  input  32  next PC from the next-PC logic (valid in DECODE/EXEC/MEM/WB)
imem_ready  input  1  instruction memory has imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
dmem_ready  input  1  data memory completes access this cycle
pc  output  32  current PC (registered)
ir  output  32  current instruction (registered)
imem_req  output  1  instruction fetch request, address = pc
dmem_req  output  1  data memory request
dmem_we  output  1  data write qualifier (valid with dmem_req)
reg_we  output  1  register file write strobe
pc_we  output  1  pc <= new_pc at end of this cycle
retire  output  1  one-cycle pulse: instruction completed
retired_count  output  32  number of retired instructions
state  output  3  FSM state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
halted  output  1  sticky halt indicator
illegal  output  1  sticky: halt caused by an unknown opcode

Behaviour:
- Reset (rst high at an edge):
  - pc=RESET_PC, ir=0, state=FETCH, retired_count=0, halted=0, illegal=0.
  - While rst is high, all strobes (imem_req, dmem_req, dmem_we, reg_we, pc_we, retire) are forced to 0.
  - Reset is honoured in any state, including a pending handshake; the request drops and no pc, ir or count update occurs.
- Strobes: Moore-decoded from registered state and ir[31:26] (op); no combinational path from the ready inputs to the requests.
- Opcodes:
  - 6'h00 R-type
  - 6'h23 lw
  - 6'h2B sw
  - 6'h04 beq
  - 6'h02 j
  - OP_HALT
  - any other value is illegal.
- FETCH:
  - imem_req=1 every cycle until imem_ready; imem_req is held and pc stays stable while waiting.
  - On imem_ready: ir<=imem_rdata, then go to DECODE.
  - Minimum 1 cycle.
- DECODE:
  - j: pc_we=1, retire=1, go to FETCH.
  - OP_HALT: go to HALT, halted<=1.
  - illegal opcode: go to HALT, halted<=1, illegal<=1.
  - otherwise go to EXEC.
- EXEC:
  - R-type and lw/sw: go to WB or MEM respectively.
  - beq: pc_we=1, retire=1, go to FETCH. new_pc already reflects the branch decision.
- MEM:
  - dmem_req=1, and dmem_we=1 for sw; both held until dmem_ready.
  - On dmem_ready, lw: go to WB.
  - On dmem_ready, sw: pc_we=1 and retire=1 in that same cycle, then go to FETCH.
- WB: reg_we=1, pc_we=1, retire=1 for exactly one cycle, then go to FETCH.
- HALT:
  - Absorbing state: all strobes 0; pc, ir and retired_count frozen.
  - Left only by reset.
  - The halt instruction does not retire.
- pc_we and retire are always asserted together and only for one cycle per instruction; pc updates only on that edge.
- retired_count increments by 1 on each retire and wraps from 32'hFFFF_FFFF to 0.
- Minimum latency with zero-wait memory, FETCH to next FETCH:
  - j: 2 cycles
  - beq: 3 cycles
  - R-type: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - Each memory wait cycle adds 1.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.

Test Plan:
- Reset, R-type 32'h0000_0020 with imem_ready immediate, new_pc=4 -> state sequence 0,1,2,4,0; reg_we, pc_we and retire high in the WB cycle; pc=4; retired_count=1.
- lw 32'h8C01_0004 with dmem_ready low for 2 cycles -> dmem_req held 3 cycles with dmem_we=0; 7 cycles total; reg_we pulses once.
- sw 32'hAC01_0004 -> in the MEM cycle with dmem_ready=1, dmem_req=dmem_we=pc_we=retire=1; reg_we never asserted.
- beq with new_pc=32'h40, then j with new_pc=32'h100 -> pc=32'h40 after 3 cycles, then pc=32'h100 after 2 more; retired_count=2.
- Opcode 6'h3F, then opcode 6'h11 after a reset -> halted=1 with illegal=0, then halted=1 with illegal=1; no strobes in HALT for 10 cycles; reset restores pc=RESET_PC.
- rst asserted during a MEM wait with dmem_ready low -> next cycle state=FETCH, pc=RESET_PC, dmem_req=0, count unchanged from 0.
